// File: rtl/aer_event_rx.sv
// 4-phase AER receiver: captures address-events into a 2-entry queue and keeps
// saturating spike/tick counters. Define AER_RX_SYNC_EN to put a 2-flop synchroniser on REQ.
module aer_event_rx #(
    parameter int unsigned M     = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [M+1:0]     AER_ADDR_i,
    input  logic             AER_REQ_i,
    output logic             AER_ACK_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [1:0]       evt_type_o,
    output logic [M-1:0]     evt_addr_o,
    input  logic             clear_i,
    output logic [CNT_W-1:0] spike_cnt_o,
    output logic [CNT_W-1:0] tick_cnt_o,
    output logic             err_o
);

    typedef enum logic [0:0] {StIdle, StAckHi} state_e;

    state_e             state_q, state_d;
    logic               req_s;
    logic               capture;
    logic               push, pop;
    logic [M+1:0]       mem_q [2];
    logic               wr_ptr_q, rd_ptr_q;
    logic [1:0]         cnt_q, cnt_d;
    logic [M+1:0]       head;
    logic [CNT_W-1:0]   spike_q, spike_d, tick_q, tick_d;
    logic               err_q, err_d;

`ifdef AER_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLK) begin
        if (RST) sync_q <= '0;
        else     sync_q <= {sync_q[0], AER_REQ_i};
    end

    assign req_s = sync_q[1];
`else
    assign req_s = AER_REQ_i;
`endif

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Full is judged on the registered count; a same-cycle pop does not help.
                if (req_s && (cnt_q != 2'd2)) begin
                    capture = 1'b1;
                    state_d = StAckHi;
                end
            end
            StAckHi: begin
                if (!req_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= StIdle;
        else     state_q <= state_d;
    end

    assign AER_ACK_o = (state_q == StAckHi);

    assign push        = capture && (AER_ADDR_i[M+1:M] != 2'b10);
    assign evt_valid_o = (cnt_q != 2'd0);
    assign pop         = evt_valid_o && evt_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 2'd1;
        else if (!push && pop) cnt_d = cnt_q - 2'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= AER_ADDR_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_d;
        end
    end

    // When empty, the slot behind the read pointer still holds the last popped head.
    assign head       = (cnt_q == 2'd0) ? mem_q[~rd_ptr_q] : mem_q[rd_ptr_q];
    assign evt_type_o = head[M+1:M];
    assign evt_addr_o = head[M-1:0];

    always_comb begin
        spike_d = spike_q;
        tick_d  = tick_q;
        err_d   = err_q;
        if (clear_i) begin
            spike_d = '0;
            tick_d  = '0;
            err_d   = 1'b0;
        end else if (capture) begin
            unique case (AER_ADDR_i[M+1:M])
                2'b00:   if (spike_q != '1) spike_d = spike_q + CNT_W'(1);
                2'b01:   if (tick_q != '1) tick_d = tick_q + CNT_W'(1);
                2'b10:   err_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            spike_q <= '0;
            tick_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            spike_q <= spike_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

    assign spike_cnt_o = spike_q;
    assign tick_cnt_o  = tick_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_aer_event_rx.sv
// Directed bench for aer_event_rx; expected timing follows AER_RX_SYNC_EN when defined.
module tb_aer_event_rx;

`ifdef AER_RX_SYNC_EN
    localparam int SyncLat = 2;
`else
    localparam int SyncLat = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  aer_addr = '0;
    logic        aer_req = 1'b0;
    logic        evt_ready = 1'b0;
    logic        clear = 1'b0;

    logic        ack, evt_valid, err;
    logic [1:0]  evt_type;
    logic [7:0]  evt_addr;
    logic [15:0] spike_cnt, tick_cnt;

    logic        s_ack, s_valid, s_err;
    logic [1:0]  s_type;
    logic [7:0]  s_addr;
    logic [3:0]  s_spike, s_tick;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    aer_event_rx #(.M(8), .CNT_W(16)) dut (
        .CLK(clk), .RST(rst), .AER_ADDR_i(aer_addr), .AER_REQ_i(aer_req), .AER_ACK_o(ack),
        .evt_valid_o(evt_valid), .evt_ready_i(evt_ready), .evt_type_o(evt_type),
        .evt_addr_o(evt_addr), .clear_i(clear), .spike_cnt_o(spike_cnt),
        .tick_cnt_o(tick_cnt), .err_o(err)
    );

    aer_event_rx #(.M(8), .CNT_W(4)) dut_sat (
        .CLK(clk), .RST(rst), .AER_ADDR_i(aer_addr), .AER_REQ_i(aer_req), .AER_ACK_o(s_ack),
        .evt_valid_o(s_valid), .evt_ready_i(evt_ready), .evt_type_o(s_type),
        .evt_addr_o(s_addr), .clear_i(clear), .spike_cnt_o(s_spike),
        .tick_cnt_o(s_tick), .err_o(s_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        aer_req = 1'b0;
        clear   = 1'b0;
        rst     = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Full 4-phase handshake with bounded waits on ACK.
    task automatic send(input logic [9:0] a);
        int n;
        aer_addr = a;
        aer_req  = 1'b1;
        n = 0;
        while (ack !== 1'b1 && n < 20) begin tick(); n++; end
        if (ack !== 1'b1) begin
            n_chk++;
            $display("FAIL send_ack_rise addr=%h got ack=%b required 1", a, ack);
        end
        aer_req = 1'b0;
        n = 0;
        while (ack !== 1'b0 && n < 20) begin tick(); n++; end
        if (ack !== 1'b0) begin
            n_chk++;
            $display("FAIL send_ack_fall addr=%h got ack=%b required 0", a, ack);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if ({ack, evt_valid, err} !== 3'b000)
            $display("FAIL reset_flags got ack/valid/err=%b required 000", {ack, evt_valid, err});
        else n_pass++;
        n_chk++; if ({evt_type, evt_addr} !== 10'h000)
            $display("FAIL reset_head got %h required 000", {evt_type, evt_addr});
        else n_pass++;
        n_chk++; if ({spike_cnt, tick_cnt} !== 32'h0)
            $display("FAIL reset_cnt got %h required 0", {spike_cnt, tick_cnt});
        else n_pass++;
    endtask

    task automatic test_single_spike();
        do_reset();
        evt_ready = 1'b1;
        aer_addr  = {2'b00, 8'h2A};
        aer_req   = 1'b1;
        repeat (SyncLat) tick();
        n_chk++; if (ack !== 1'b0) $display("FAIL spike_ack_early got %b required 0", ack);
        else n_pass++;
        tick();
        n_chk++; if ({ack, evt_valid} !== 2'b11)
            $display("FAIL spike_ack_valid got %b required 11", {ack, evt_valid});
        else n_pass++;
        n_chk++; if ({evt_type, evt_addr} !== {2'b00, 8'h2A})
            $display("FAIL spike_head got %h required 02a", {evt_type, evt_addr});
        else n_pass++;
        n_chk++; if (spike_cnt !== 16'd1) $display("FAIL spike_cnt got %0d required 1", spike_cnt);
        else n_pass++;
        aer_req = 1'b0;
        repeat (SyncLat) tick();
        n_chk++; if (ack !== 1'b1) $display("FAIL spike_ack_hold got %b required 1", ack);
        else n_pass++;
        tick();
        n_chk++; if (ack !== 1'b0) $display("FAIL spike_ack_drop got %b required 0", ack);
        else n_pass++;
        n_chk++; if ({evt_valid, evt_addr} !== {1'b0, 8'h2A})
            $display("FAIL spike_popped_hold got %h required 02a", {evt_valid, evt_addr});
        else n_pass++;
        repeat (4) tick();
        n_chk++; if ({spike_cnt, evt_valid} !== {16'd1, 1'b0})
            $display("FAIL spike_one_event got cnt=%0d valid=%b required 1/0", spike_cnt, evt_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        evt_ready = 1'b0;
        send({2'b00, 8'h01});
        send({2'b00, 8'h02});
        aer_addr = {2'b00, 8'h03};
        aer_req  = 1'b1;
        repeat (SyncLat + 3) tick();
        n_chk++; if (ack !== 1'b0) $display("FAIL bp_stall_ack got %b required 0", ack);
        else n_pass++;
        n_chk++; if ({evt_valid, evt_addr} !== {1'b1, 8'h01})
            $display("FAIL bp_head1 got %h required 101", {evt_valid, evt_addr});
        else n_pass++;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        n_chk++; if ({ack, evt_addr} !== {1'b0, 8'h02})
            $display("FAIL bp_pop1 got ack/addr=%h required 002", {ack, evt_addr});
        else n_pass++;
        tick();
        n_chk++; if ({ack, evt_addr} !== {1'b1, 8'h02})
            $display("FAIL bp_ack3 got ack/addr=%h required 102", {ack, evt_addr});
        else n_pass++;
        aer_req = 1'b0;
        repeat (SyncLat + 1) tick();
        n_chk++; if (ack !== 1'b0) $display("FAIL bp_ack3_drop got %b required 0", ack);
        else n_pass++;
        evt_ready = 1'b1;
        tick();
        n_chk++; if ({evt_valid, evt_addr} !== {1'b1, 8'h03})
            $display("FAIL bp_head3 got %h required 103", {evt_valid, evt_addr});
        else n_pass++;
        tick();
        n_chk++; if ({evt_valid, evt_addr} !== {1'b0, 8'h03})
            $display("FAIL bp_empty got %h required 003", {evt_valid, evt_addr});
        else n_pass++;
        n_chk++; if (spike_cnt !== 16'd3) $display("FAIL bp_spike_cnt got %0d required 3", spike_cnt);
        else n_pass++;
    endtask

    task automatic test_reserved_tick();
        do_reset();
        evt_ready = 1'b0;
        send({2'b10, 8'h05});
        n_chk++; if ({err, evt_valid} !== 2'b10)
            $display("FAIL rsv_err got err/valid=%b required 10", {err, evt_valid});
        else n_pass++;
        send({2'b01, 8'h00});
        n_chk++; if ({evt_valid, evt_type, evt_addr} !== {1'b1, 2'b01, 8'h00})
            $display("FAIL tick_head got %h required 500", {evt_valid, evt_type, evt_addr});
        else n_pass++;
        n_chk++; if ({tick_cnt, spike_cnt} !== {16'd1, 16'd0})
            $display("FAIL tick_cnts got tick=%0d spike=%0d required 1/0", tick_cnt, spike_cnt);
        else n_pass++;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_chk++; if ({err, tick_cnt} !== 17'd0)
            $display("FAIL clear got err=%b tick=%0d required 0/0", err, tick_cnt);
        else n_pass++;
        n_chk++; if (evt_valid !== 1'b1) $display("FAIL clear_queue got %b required 1", evt_valid);
        else n_pass++;
        evt_ready = 1'b1;
        tick();
        n_chk++; if (evt_valid !== 1'b0) $display("FAIL tick_only_one got %b required 0", evt_valid);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        evt_ready = 1'b1;
        for (int i = 0; i < 20; i++) send({2'b00, 8'(i)});
        n_chk++; if (s_spike !== 4'd15) $display("FAIL sat_cnt got %0d required 15", s_spike);
        else n_pass++;
        n_chk++; if (spike_cnt !== 16'd20) $display("FAIL wide_cnt got %0d required 20", spike_cnt);
        else n_pass++;
        send({2'b00, 8'hFF});
        n_chk++; if (s_spike !== 4'd15) $display("FAIL sat_hold got %0d required 15", s_spike);
        else n_pass++;
    endtask

    task automatic test_reset_mid_handshake();
        int n;
        do_reset();
        evt_ready = 1'b0;
        aer_addr  = {2'b00, 8'h07};
        aer_req   = 1'b1;
        n = 0;
        while (ack !== 1'b1 && n < 20) begin tick(); n++; end
        n_chk++; if (ack !== 1'b1) $display("FAIL mid_ack_rise got %b required 1", ack);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_chk++; if ({ack, evt_valid, spike_cnt} !== 18'd0)
            $display("FAIL mid_reset got ack=%b valid=%b cnt=%0d required 0", ack, evt_valid,
                     spike_cnt);
        else n_pass++;
        rst = 1'b0;
        repeat (SyncLat) tick();
        n_chk++; if (ack !== 1'b0) $display("FAIL mid_recap_early got %b required 0", ack);
        else n_pass++;
        tick();
        n_chk++; if ({ack, evt_valid, evt_addr} !== {2'b11, 8'h07})
            $display("FAIL mid_recap got %h required 307", {ack, evt_valid, evt_addr});
        else n_pass++;
        n_chk++; if (spike_cnt !== 16'd1) $display("FAIL mid_recap_cnt got %0d required 1", spike_cnt);
        else n_pass++;
        aer_req = 1'b0;
        repeat (SyncLat + 1) tick();
        n_chk++; if (ack !== 1'b0) $display("FAIL mid_ack_drop got %b required 0", ack);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_spike();
        test_backpressure();
        test_reserved_tick();
        test_saturation();
        test_reset_mid_handshake();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aer_event_rx.md
Name: aer_event_rx

Overview:
- 4-phase AER receiver that sits directly downstream of the spike core's AER output stage (AER_ADDR/AER_REQ/AER_ACK).
- Captures each address-event, decodes its 2-bit event type, and buffers it in a 2-entry queue.
- Presents events as a valid/ready stream to the LIF neuron update logic.
- Keeps saturating spike/tick counters and a sticky error flag for software readout.

Parameters:
- M, 8, neuron address width; AER address is M+2 bits.
- CNT_W, 16, width of the spike and tick event counters.

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- AER_ADDR_i  in  M+2  event word: [M+1:M] type, [M-1:0] neuron address.
- AER_REQ_i  in  1  4-phase request from sender.
- AER_ACK_o  out  1  4-phase acknowledge to sender.
- evt_valid_o  out  1  queue head valid.
- evt_ready_i  in  1  consumer accepts head.
- evt_type_o  out  2  type of head event.
- evt_addr_o  out  M  address of head event.
- clear_i  in  1  synchronous clear of counters and error flag.
- spike_cnt_o  out  CNT_W  accepted type-00 events, saturating.
- tick_cnt_o  out  CNT_W  accepted type-01 events, saturating.
- err_o  out  1  sticky: reserved type 10 received.

Behaviour:
- Event types: 00 neuron spike, 01 tick advance, 10 reserved, 11 end-of-sample.
- Internal request: req_s = AER_REQ_i in the default build; see Optional Feature for the synchronised build.
- Reset (RST=1 at an edge):
  - AER_ACK_o=0, evt_valid_o=0, evt_type_o=0, evt_addr_o=0.
  - Counters = 0, err_o=0, queue emptied, FSM=IDLE.
  - Reset mid-handshake aborts it. If REQ is still high after reset releases, it is handled as a new request.
- FSM states: IDLE, ACK_HI.
- IDLE:
  - At an edge with req_s=1 and queue count<2: latch AER_ADDR_i, set AER_ACK_o=1, go to ACK_HI.
  - If count==2: wait, ACK stays 0.
  - Full is evaluated on the registered count. A pop in the same cycle does not free space for that edge.
- ACK_HI:
  - At an edge with req_s=0: AER_ACK_o=0, go to IDLE.
  - No capture is possible in ACK_HI, so each handshake produces exactly one event.
- Capture:
  - Types 00/01/11 are pushed to the queue.
  - Type 10 is still ACKed but not pushed; err_o set to 1 and held.
  - Type 00 increments spike_cnt_o, type 01 increments tick_cnt_o, both at the capture edge. Each saturates at 2^CNT_W-1.
- Queue:
  - 2-entry FIFO, head combinational from storage.
  - evt_valid_o = (count!=0); pop when evt_valid_o & evt_ready_i.
  - Capture and pop in the same edge with count==1: count stays 1, order preserved.
  - evt_type_o/evt_addr_o hold the last head value when empty.
- Latency (default build):
  - REQ high before edge k → ACK_o and evt_valid_o high after edge k.
  - REQ low before edge j → ACK_o low after edge j.
- clear_i:
  - Zeros counters and err_o at the edge; the queue and FSM are unaffected.
  - A capture on the same edge as clear_i is not counted, and clear wins for err_o.
- Address bits are captured in the same edge REQ is seen. Sender guarantees the address is stable while REQ=1.

Optional Feature:
- Macro: AER_RX_SYNC_EN.
- Defined: AER_REQ_i passes through a 2-flop synchroniser (reset to 0) before use as req_s. Capture and ACK assertion/deassertion each occur 2 cycles later than in the default build. AER_ADDR_i is sampled at the capture edge, which is valid because the address is held stable while REQ=1.
- Undefined: req_s = AER_REQ_i directly, zero added latency.

Test Plan:
- Single spike, default build: REQ=1 with ADDR={2'b00,8'h2A}, ready=1.
  - ACK high one edge later.
  - evt_valid=1, type=00, addr=0x2A.
  - spike_cnt=1.
  - Drop REQ → ACK low next edge.
- Backpressure, ready=0: three handshakes with addr 0x01,0x02,0x03.
  - First two ACKed; third stalls with ACK=0 while count==2.
  - Raising ready pops 0x01; the next edge ACKs 0x03.
  - Output order 0x01,0x02,0x03.
- Reserved and tick: send {10,8'h05} then {01,8'h00}.
  - Both ACKed; err_o=1.
  - Only the tick event appears on the stream; tick_cnt=1, spike_cnt=0.
  - clear_i pulse → err_o=0, tick_cnt=0.
- Saturation with CNT_W=4: send 20 spikes.
  - spike_cnt_o=15 and holds.
- Reset mid-handshake: assert RST while in ACK_HI with REQ=1.
  - ACK=0, valid=0, counters=0.
  - After RST release with REQ still 1, the event is recaptured one edge later.
- AER_RX_SYNC_EN defined: REQ rise before edge k.
  - ACK high after edge k+2; ACK low 3 edges after REQ falls.
  - Exactly one event per handshake.
